// File: rtl/core_pkg.sv
// Shared core definitions: control bundle layout, opcodes and field positions.
package core_pkg;

    // Control bundle, MSB first: {J,JC,INA,RM,WM,SIN,SOUT,WR,NEQ}
    typedef struct packed {
        logic j;
        logic jc;
        logic ina;
        logic rm;
        logic wm;
        logic sin;
        logic sout;
        logic wr;
        logic neq;
    } ctrl_t;

    localparam int unsigned CtrlW   = 9;
    localparam int unsigned OpcodeW = 3;
    localparam int unsigned FunctW  = 3;

    localparam logic [OpcodeW-1:0] OpNop = 3'b000;
    localparam logic [OpcodeW-1:0] OpLd  = 3'b001;
    localparam logic [OpcodeW-1:0] OpAlu = 3'b010;
    localparam logic [OpcodeW-1:0] OpSt  = 3'b011;
    localparam logic [OpcodeW-1:0] OpIn  = 3'b100;
    localparam logic [OpcodeW-1:0] OpOut = 3'b101;
    localparam logic [OpcodeW-1:0] OpBr  = 3'b110;
    localparam logic [OpcodeW-1:0] OpJmp = 3'b111;

    // Instruction layout {opcode, rs, funct}: funct at bit 0, rs just above it.
    localparam int unsigned FunctLsb = 0;
    localparam int unsigned RsLsb    = FunctW;

    function automatic int unsigned inst_width(input int unsigned rs_w);
        return OpcodeW + rs_w + FunctW;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF->ID, WB->ID and ID->EX signals of the decode stage.
interface decode_stage_if
    import core_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned REG_CNT = 4
) ();
    localparam int unsigned RS_W   = $clog2(REG_CNT);
    localparam int unsigned INST_W = inst_width(RS_W);

    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst;
    logic              flush;
    logic              wb_en;
    logic [RS_W-1:0]   wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_regval;
    logic [DATA_W-1:0] out_imm;
    logic [2:0]        out_funct;
    logic [RS_W-1:0]   out_rs;
    ctrl_t             out_ctrl;

    // Decode-stage view.
    modport slave (
        input  in_valid, in_pc, in_inst, flush, wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_regval, out_imm, out_funct, out_rs, out_ctrl
    );

    // Surrounding-pipeline view.
    modport master (
        output in_valid, in_pc, in_inst, flush, wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_regval, out_imm, out_funct, out_rs, out_ctrl
    );
endinterface

// File: rtl/controlUnit.sv
// Opcode to control-bundle decode.
module controlUnit
    import core_pkg::*;
(
    input  logic [OpcodeW-1:0] opcode_i,
    output ctrl_t              ctrl_o
);
    // Purely combinational opcode decode.
    always_comb begin
        ctrl_o = '0;
        case (opcode_i)
            OpLd:    begin ctrl_o.rm = 1'b1; ctrl_o.wr = 1'b1; end
            OpAlu:   ctrl_o.wr = 1'b1;
            OpSt:    ctrl_o.wm = 1'b1;
            OpIn:    begin ctrl_o.sin = 1'b1; ctrl_o.wr = 1'b1; end
            OpOut:   ctrl_o.sout = 1'b1;
            OpBr:    begin ctrl_o.jc = 1'b1; ctrl_o.neq = 1'b1; end
            OpJmp:   begin ctrl_o.j = 1'b1; ctrl_o.ina = 1'b1; end
            default: ctrl_o = '0;
        endcase
    end
endmodule

// File: rtl/reg_file.sv
// REG_CNT x DATA_W register file, one read and one write port, write-through read.
module reg_file #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned REG_CNT = 4,
    parameter int unsigned RS_W    = $clog2(REG_CNT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [RS_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RS_W-1:0]   raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] regs_q [REG_CNT];

    // Storage: written on every strobe, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_CNT); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read port forwards the value being written this cycle.
    always_comb begin
        rdata_o = regs_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: register read, immediate/control decode, hazard
// scoreboard and the ID/EX pipeline register.
module decode_stage
    import core_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned REG_CNT = 4
) (
    input logic           clock,
    input logic           reset,
    decode_stage_if.slave bus
);
    localparam int unsigned RS_W   = $clog2(REG_CNT);
    localparam int unsigned INST_W = inst_width(RS_W);
    localparam int unsigned IMM_W  = INST_W - 3;

    logic [INST_W-1:0]  inst;
    logic [OpcodeW-1:0] opcode;
    logic [RS_W-1:0]    rs;
    logic [2:0]         funct;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  rdata;
    ctrl_t              ctrl;

    logic               out_valid_q;
    logic [PC_W-1:0]    pc_q;
    logic [DATA_W-1:0]  regval_q;
    logic [DATA_W-1:0]  imm_q;
    logic [2:0]         funct_q;
    logic [RS_W-1:0]    rs_q;
    ctrl_t              ctrl_q;
    logic [REG_CNT-1:0] pend_q, pend_d;

    logic hazard, ready, accept, depart;

    assign inst   = bus.in_inst;
    assign opcode = inst[INST_W-1 -: OpcodeW];
    assign rs     = inst[RsLsb +: RS_W];
    assign funct  = inst[FunctLsb +: FunctW];

    // Sign-extend (or truncate) the low IMM_W instruction bits to DATA_W.
    for (genvar g = 0; g < DATA_W; g++) begin : g_imm
        if (g < IMM_W) begin : g_fld
            assign imm_ext[g] = inst[g];
        end else begin : g_sgn
            assign imm_ext[g] = inst[IMM_W-1];
        end
    end

    controlUnit u_ctrl (
        .opcode_i (opcode),
        .ctrl_o   (ctrl)
    );

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .RS_W    (RS_W)
    ) u_rf (
        .clock   (clock),
        .reset   (reset),
        .we_i    (bus.wb_en),
        .waddr_i (bus.wb_addr),
        .wdata_i (bus.wb_data),
        .raddr_i (rs),
        .rdata_o (rdata)
    );

    // Stall on a pending rs unless it is being written back now, or on a WR
    // instruction to rs still sitting in ID/EX (even if it departs this cycle).
    always_comb begin
        hazard = (pend_q[rs] && !(bus.wb_en && (bus.wb_addr == rs))) ||
                 (out_valid_q && ctrl_q.wr && (rs_q == rs));
        ready  = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
        accept = bus.in_valid && ready;
        depart = out_valid_q && bus.out_ready;
    end

    // Scoreboard next state: clear on write-back, set on WR departure (set wins).
    always_comb begin
        pend_d = pend_q;
        if (bus.wb_en) begin
            pend_d[bus.wb_addr] = 1'b0;
        end
        if (depart && ctrl_q.wr) begin
            pend_d[rs_q] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ID/EX register: load on accept, bubble on departure or flush, else hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            regval_q    <= '0;
            imm_q       <= '0;
            funct_q     <= '0;
            rs_q        <= '0;
            ctrl_q      <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            pc_q        <= bus.in_pc;
            regval_q    <= rdata;
            imm_q       <= imm_ext;
            funct_q     <= funct;
            rs_q        <= rs;
            ctrl_q      <= ctrl;
        end else if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = pc_q;
    assign bus.out_regval = regval_q;
    assign bus.out_imm    = imm_q;
    assign bus.out_funct  = funct_q;
    assign bus.out_rs     = rs_q;
    assign bus.out_ctrl   = ctrl_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default build plus a DATA_W=16/REG_CNT=8 build.
module tb_decode_stage;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    decode_stage_if #(.DATA_W(8),  .PC_W(8), .REG_CNT(4)) bus0 ();
    decode_stage_if #(.DATA_W(16), .PC_W(8), .REG_CNT(8)) bus1 ();

    decode_stage #(.DATA_W(8), .PC_W(8), .REG_CNT(4)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    decode_stage #(.DATA_W(16), .PC_W(8), .REG_CNT(8)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] tbl_inst   [4];
    logic [7:0] tbl_regval [4];
    logic [7:0] tbl_imm    [4];
    logic [8:0] tbl_ctrl   [4];

    initial begin
        tbl_inst[0] = 8'b000_00_101; tbl_regval[0] = 8'h00; tbl_imm[0] = 8'h05; tbl_ctrl[0] = 9'h000;
        tbl_inst[1] = 8'b000_01_111; tbl_regval[1] = 8'h5A; tbl_imm[1] = 8'h0F; tbl_ctrl[1] = 9'h000;
        tbl_inst[2] = 8'b000_10_100; tbl_regval[2] = 8'h00; tbl_imm[2] = 8'hF4; tbl_ctrl[2] = 9'h000;
        tbl_inst[3] = 8'b011_11_000; tbl_regval[3] = 8'h00; tbl_imm[3] = 8'hF8; tbl_ctrl[3] = 9'h010;

        reset = 1'b1;
        bus0.in_valid = 0; bus0.in_pc = '0; bus0.in_inst = '0; bus0.flush = 0;
        bus0.wb_en = 0; bus0.wb_addr = '0; bus0.wb_data = '0; bus0.out_ready = 0;
        bus1.in_valid = 0; bus1.in_pc = '0; bus1.in_inst = '0; bus1.flush = 0;
        bus1.wb_en = 0; bus1.wb_addr = '0; bus1.wb_data = '0; bus1.out_ready = 0;
        tick();
        tick();

        // Reset state.
        check_eq("rst_valid", 32'(bus0.out_valid), 32'h0);
        check_eq("rst_pc", 32'(bus0.out_pc), 32'h0);
        check_eq("rst_ctrl", 32'(bus0.out_ctrl), 32'h0);
        check_eq("rst_ready", 32'(bus0.in_ready), 32'h1);
        reset = 1'b0;

        // First WR instruction, one-cycle latency.
        bus0.in_valid = 1; bus0.in_inst = 8'b010_01_011; bus0.in_pc = 8'h10; bus0.out_ready = 1;
        #1 check_eq("first_ready", 32'(bus0.in_ready), 32'h1);
        tick();
        check_eq("first_valid", 32'(bus0.out_valid), 32'h1);
        check_eq("first_pc", 32'(bus0.out_pc), 32'h10);
        check_eq("first_rs", 32'(bus0.out_rs), 32'h1);
        check_eq("first_funct", 32'(bus0.out_funct), 32'h3);
        check_eq("first_imm", 32'(bus0.out_imm), 32'h0B);
        check_eq("first_ctrl", 32'(bus0.out_ctrl), 32'h002);
        check_eq("first_regval", 32'(bus0.out_regval), 32'h0);

        // RAW follower on r1 stalls three cycles, then goes in the write-back cycle.
        bus0.in_inst = 8'b000_01_000; bus0.in_pc = 8'h11;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq($sformatf("raw_stall%0d", i), 32'(bus0.in_ready), 32'h0);
            tick();
        end
        bus0.wb_en = 1; bus0.wb_addr = 2'd1; bus0.wb_data = 8'h5A;
        #1 check_eq("raw_bypass_ready", 32'(bus0.in_ready), 32'h1);
        tick();
        bus0.wb_en = 0;
        check_eq("raw_valid", 32'(bus0.out_valid), 32'h1);
        check_eq("raw_pc", 32'(bus0.out_pc), 32'h11);
        check_eq("raw_regval", 32'(bus0.out_regval), 32'h5A);

        // Downstream back-pressure for four cycles: outputs hold.
        bus0.out_ready = 0; bus0.in_inst = 8'b000_00_000; bus0.in_pc = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("bp_ready%0d", i), 32'(bus0.in_ready), 32'h0);
            check_eq($sformatf("bp_valid%0d", i), 32'(bus0.out_valid), 32'h1);
            check_eq($sformatf("bp_pc%0d", i), 32'(bus0.out_pc), 32'h11);
            check_eq($sformatf("bp_regval%0d", i), 32'(bus0.out_regval), 32'h5A);
            tick();
        end

        // Release: back-to-back accepts.
        bus0.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus0.in_inst = tbl_inst[i];
            bus0.in_pc = 8'(8'h20 + i);
            #1 check_eq($sformatf("b2b_ready%0d", i), 32'(bus0.in_ready), 32'h1);
            tick();
            check_eq($sformatf("b2b_pc%0d", i), 32'(bus0.out_pc), 32'(8'h20 + i));
            check_eq($sformatf("b2b_regval%0d", i), 32'(bus0.out_regval), 32'(tbl_regval[i]));
            check_eq($sformatf("b2b_imm%0d", i), 32'(bus0.out_imm), 32'(tbl_imm[i]));
            check_eq($sformatf("b2b_ctrl%0d", i), 32'(bus0.out_ctrl), 32'(tbl_ctrl[i]));
        end

        // Flush while EX is stalled: nothing accepted, ID/EX killed.
        bus0.out_ready = 0; bus0.flush = 1;
        bus0.in_inst = 8'b010_10_000; bus0.in_pc = 8'h30;
        #1 check_eq("flush_ready", 32'(bus0.in_ready), 32'h0);
        tick();
        bus0.flush = 0;
        check_eq("flush_valid", 32'(bus0.out_valid), 32'h0);
        check_eq("flush_pc_hold", 32'(bus0.out_pc), 32'h23);
        bus0.out_ready = 1; bus0.in_inst = 8'b000_10_000; bus0.in_pc = 8'h31;
        #1 check_eq("flush_no_pend", 32'(bus0.in_ready), 32'h1);
        tick();

        // Build pend[2]=1 with a live instruction held in ID/EX, then reset mid-stall.
        bus0.in_inst = 8'b010_10_001; bus0.in_pc = 8'h40;
        tick();
        bus0.in_inst = 8'b010_11_000; bus0.in_pc = 8'h41;
        #1 check_eq("pre_rst_ready", 32'(bus0.in_ready), 32'h1);
        tick();
        bus0.out_ready = 0; bus0.in_inst = 8'b000_10_000; bus0.in_pc = 8'h42;
        #1 check_eq("pre_rst_stall", 32'(bus0.in_ready), 32'h0);
        tick();
        check_eq("pre_rst_valid", 32'(bus0.out_valid), 32'h1);
        check_eq("pre_rst_pc", 32'(bus0.out_pc), 32'h41);
        #2 reset = 1'b1;
        #1 check_eq("arst_valid", 32'(bus0.out_valid), 32'h0);
        check_eq("arst_pc", 32'(bus0.out_pc), 32'h0);
        check_eq("arst_rs", 32'(bus0.out_rs), 32'h0);
        check_eq("arst_ctrl", 32'(bus0.out_ctrl), 32'h0);
        check_eq("arst_pend_clear", 32'(bus0.in_ready), 32'h1);
        bus0.in_valid = 0;
        #1 reset = 1'b0;
        tick();
        bus0.in_valid = 1; bus0.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus0.in_inst = {3'b000, 2'(i), 3'b000};
            bus0.in_pc = 8'(8'h50 + i);
            tick();
            check_eq($sformatf("arst_r%0d", i), 32'(bus0.out_regval), 32'h0);
            check_eq($sformatf("arst_rdpc%0d", i), 32'(bus0.out_pc), 32'(8'h50 + i));
        end
        bus0.in_valid = 0;

        // Wide build: 16-bit data, 8 registers.
        bus1.out_ready = 1;
        bus1.wb_en = 1; bus1.wb_addr = 3'd7; bus1.wb_data = 16'hBEEF;
        tick();
        bus1.wb_en = 0;
        bus1.in_valid = 1; bus1.in_inst = 9'b000_111_000; bus1.in_pc = 8'h60;
        #1 check_eq("w_ready", 32'(bus1.in_ready), 32'h1);
        tick();
        check_eq("w_r7", 32'(bus1.out_regval), 32'hBEEF);
        check_eq("w_imm_r7", 32'(bus1.out_imm), 32'hFFF8);
        check_eq("w_rs", 32'(bus1.out_rs), 32'h7);
        bus1.in_inst = 9'b000_100_000; bus1.in_pc = 8'h61;
        tick();
        check_eq("w_imm", 32'(bus1.out_imm), 32'hFFE0);
        check_eq("w_r4", 32'(bus1.out_regval), 32'h0);
        check_eq("w_pc", 32'(bus1.out_pc), 32'h61);
        bus1.in_valid = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
